// File: rtl/ram_sdp_clr.sv
// ram_sdp_clr: simple-dual-port RAM with registered write-first read and a post-reset clear sweep
module ram_sdp_clr #(
    parameter int                DATA_W    = 8,
    parameter int                ADDR_W    = 5,
    parameter int                DEPTH     = 32,
    parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wena,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              ren,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid,
    output logic              busy
);
    typedef enum logic {CLEAR, RUN} state_t;
    localparam logic [ADDR_W:0] DEPTH_P = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] LAST    = (ADDR_W+1)'(DEPTH - 1);
    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W:0]   r_ptr;
    logic [ADDR_W:0]   w_ptr_nxt;
    logic              r_busy;
    logic [DATA_W-1:0] r_rdata;
    logic              r_rvalid;
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic              w_clr;
    logic              w_waddr_ok;
    logic              w_raddr_ok;
    logic              w_mem_we;
    logic [ADDR_W-1:0] w_mem_addr;
    logic [DATA_W-1:0] w_mem_data;
    logic              w_rd;
    logic [DATA_W-1:0] w_rdata_nxt;
    assign rdata  = r_rdata;
    assign rvalid = r_rvalid;
    assign busy   = r_busy;
    // next state, sweep pointer, and the shared write-port / read-data selection
    always_comb begin
        w_clr       = r_state == CLEAR;
        w_state_nxt = (w_clr && r_ptr != LAST) ? CLEAR : RUN;
        w_ptr_nxt   = w_clr ? r_ptr + (ADDR_W+1)'(1) : r_ptr;
        w_waddr_ok  = {1'b0, waddr} < DEPTH_P;
        w_raddr_ok  = {1'b0, raddr} < DEPTH_P;
        w_mem_we    = w_clr || (wena && w_waddr_ok);
        w_mem_addr  = w_clr ? r_ptr[ADDR_W-1:0] : waddr;
        w_mem_data  = w_clr ? CLEAR_VAL : wdata;
        w_rd        = !w_clr && ren;
        w_rdata_nxt = !w_raddr_ok ? CLEAR_VAL : (wena && waddr == raddr) ? wdata : r_mem[raddr];
    end
    // sweep FSM register; busy is registered so it mirrors the upcoming state
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= CLEAR;
            r_ptr   <= '0;
            r_busy  <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_busy  <= w_state_nxt == CLEAR;
        end
    end
    // registered read port; rdata only moves on an accepted read
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata  <= '0;
            r_rvalid <= 1'b0;
        end else begin
            r_rvalid <= w_rd;
            if (w_rd) r_rdata <= w_rdata_nxt;
        end
    end
    // storage write port, shared by the clear sweep and user writes
    always_ff @(posedge clk) begin
        if (!rst && w_mem_we) r_mem[w_mem_addr] <= w_mem_data;
    end
endmodule
